// File: rtl/issue_scoreboard_if.sv
// Bundle of the issue/writeback signals exchanged between the read/issue stage and the scoreboard.
// The master side requests issue and reports writebacks; the slave side is the scoreboard itself.
interface issue_scoreboard_if;
    logic             flush;
    logic [1:0]       issue_req;
    logic [3:0]       src_valid;
    logic [3:0][4:0]  src_addr;
    logic [1:0]       dst_valid;
    logic [1:0][4:0]  dst_addr;
    logic [1:0]       wb_ena;
    logic [1:0][4:0]  wb_addr;
    logic [1:0]       issue_grant;
    logic [3:0]       src_ready;
    logic             underflow_err;
    logic [31:0]      stall_cnt;

    modport master (
        output flush, issue_req, src_valid, src_addr, dst_valid, dst_addr, wb_ena, wb_addr,
        input  issue_grant, src_ready, underflow_err, stall_cnt
    );

    modport slave (
        input  flush, issue_req, src_valid, src_addr, dst_valid, dst_addr, wb_ena, wb_addr,
        output issue_grant, src_ready, underflow_err, stall_cnt
    );
endinterface

// File: rtl/issue_scoreboard.sv
// Register-busy scoreboard for the dual-issue stage: per-register pending-write counters gate issue
// until every source operand is committed in the 4R/2W register file. Register 0 is never tracked.
module issue_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 2
) (
    input  logic              clk,
    input  logic              rst,
    issue_scoreboard_if.slave sb
);
    localparam int AW = 5;
    localparam logic [CNT_W:0] MAX_C = (CNT_W+1)'((1 << CNT_W) - 1);

    logic [CNT_W-1:0] cnt_r      [NUM_REGS];
    logic [CNT_W-1:0] cnt_next_s [NUM_REGS];
    logic             underflow_err_r;
    logic [31:0]      stall_cnt_r;
    logic             underflow_s;
    logic [3:0]       src_ready_s;
    logic [1:0]       grant_s;
    logic             dst_ok0_s;
    logic             dst_ok1_s;
    logic             raw_hit_s;
    logic             same_dst_s;

    // Pending count of a register; register 0 and out-of-range addresses read as idle.
    function automatic logic [CNT_W-1:0] cnt_of(input logic [AW-1:0] a,
                                                 input logic [CNT_W-1:0] cv [NUM_REGS]);
        logic [CNT_W-1:0] v;
        if (a == AW'(0) || int'(a) >= NUM_REGS) begin
            v = CNT_W'(0);
        end else begin
            v = cv[a];
        end
        return v;
    endfunction

    function automatic logic [1:0] count_hits(input logic [1:0] en,
                                              input logic [1:0][AW-1:0] addr,
                                              input logic [AW-1:0] r);
        return {1'b0, en[0] && (addr[0] == r)} + {1'b0, en[1] && (addr[1] == r)};
    endfunction

    // Operand readiness looks only at committed counters: no writeback bypass.
    always_comb begin
        src_ready_s = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            src_ready_s[i] = !sb.src_valid[i] || (cnt_of(sb.src_addr[i], cnt_r) == CNT_W'(0));
        end
    end

    // In-order dual-issue grant with intra-pair RAW and destination-saturation checks.
    always_comb begin
        same_dst_s = sb.dst_valid[0] && (sb.dst_addr[0] == sb.dst_addr[1]);
        dst_ok0_s  = !sb.dst_valid[0] || (sb.dst_addr[0] == AW'(0)) ||
                     ({1'b0, cnt_of(sb.dst_addr[0], cnt_r)} < MAX_C);
        dst_ok1_s  = !sb.dst_valid[1] || (sb.dst_addr[1] == AW'(0)) ||
                     (({1'b0, cnt_of(sb.dst_addr[1], cnt_r)} + {CNT_W'(0), same_dst_s}) < MAX_C);
        raw_hit_s  = sb.dst_valid[0] && (sb.dst_addr[0] != AW'(0)) &&
                     ((sb.src_valid[2] && (sb.src_addr[2] == sb.dst_addr[0])) ||
                      (sb.src_valid[3] && (sb.src_addr[3] == sb.dst_addr[0])));
        grant_s    = 2'b00;
        grant_s[0] = !rst && !sb.flush && sb.issue_req[0] &&
                     src_ready_s[0] && src_ready_s[1] && dst_ok0_s;
        grant_s[1] = grant_s[0] && sb.issue_req[1] && src_ready_s[2] && src_ready_s[3] &&
                     !raw_hit_s && dst_ok1_s;
    end

    // Next counter values: grants add, writebacks subtract, clamping at zero on underflow.
    always_comb begin : cnt_next_calc
        logic [CNT_W:0] sum_v;
        logic [1:0]     dec_v;
        sum_v       = (CNT_W+1)'(0);
        dec_v       = 2'b00;
        underflow_s = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_next_s[r] = CNT_W'(0);
        end
        for (int r = 1; r < NUM_REGS; r++) begin
            sum_v = (CNT_W+1)'(cnt_r[r]) +
                    (CNT_W+1)'(count_hits(grant_s & sb.dst_valid, sb.dst_addr, AW'(r)));
            dec_v = count_hits(sb.wb_ena, sb.wb_addr, AW'(r));
            if (sum_v < (CNT_W+1)'(dec_v)) begin
                underflow_s   = 1'b1;
                cnt_next_s[r] = CNT_W'(0);
            end else begin
                cnt_next_s[r] = CNT_W'(sum_v - (CNT_W+1)'(dec_v));
            end
        end
    end

    // Pending-write counters; flush discards same-cycle grants and writebacks.
    always_ff @(posedge clk) begin
        if (rst || sb.flush) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_r[r] <= CNT_W'(0);
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_r[r] <= cnt_next_s[r];
            end
        end
    end

    // Sticky underflow flag and free-running stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            underflow_err_r <= 1'b0;
            stall_cnt_r     <= 32'd0;
        end else begin
            if (!sb.flush && underflow_s) begin
                underflow_err_r <= 1'b1;
            end else begin
                underflow_err_r <= underflow_err_r;
            end
            if (!sb.flush && sb.issue_req[0] && !grant_s[0]) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    assign sb.issue_grant   = grant_s;
    assign sb.src_ready     = src_ready_s;
    assign sb.underflow_err = underflow_err_r;
    assign sb.stall_cnt     = stall_cnt_r;
endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- Register-busy scoreboard for the dual-issue read/issue stage, directly upstream of the 4-read/2-write register file.
- Tracks in-flight writes per architectural register and grants issue only when all source operands are committed in the register file.
- Its writeback inputs are the same 2 write ports that drive the register file.
- Register 0 is never tracked: always ready, never busy.

Parameters:
NUM_REGS, 32, number of architectural registers; addresses are 5 bits.
CNT_W, 2, width of each pending-write counter; at most 2^CNT_W-1 in-flight writes per register (3 by default).

Ports:
clk  input  1  clock.
rst  input  1  synchronous reset, active-high.
flush  input  1  pipeline flush; clears all pending counters.
issue_req  input  2  slot request; [0] is the older instruction, [1] the younger.
src_valid  input  4  source-operand valid; [0],[1] belong to slot0, [2],[3] to slot1.
src_addr  input  4x5  source register addresses, indexed as src_valid.
dst_valid  input  2  slot writes a destination register.
dst_addr  input  2x5  destination register per slot.
wb_ena  input  2  writeback enable, same as register file write_ena.
wb_addr  input  2x5  writeback address, same as register file write_addr.
issue_grant  output  2  slot issues this cycle (combinational).
src_ready  output  4  per-operand ready status (combinational).
underflow_err  output  1  sticky protocol error.
stall_cnt  output  32  count of cycles with issue_req[0]=1 and issue_grant[0]=0.

Behaviour:
- State: cnt[1..NUM_REGS-1], each CNT_W bits. cnt[0] does not exist and reads as 0.
- src_ready[i] = !src_valid[i] | src_addr[i]==0 | cnt[src_addr[i]]==0.
  - No same-cycle bypass from wb: the register file has none, so an operand becomes ready the cycle after its last writeback.
- issue_grant[0] = issue_req[0] & src_ready[0] & src_ready[1] & dst_ok0.
  - dst_ok0 = !dst_valid[0] | dst_addr[0]==0 | cnt[dst_addr[0]] < MAX.
- issue_grant[1] requires all of the following (in-order; slot1 never issues alone):
  - issue_grant[0] & issue_req[1] & src_ready[2] & src_ready[3].
  - RAW within the pair: no valid slot1 source equals dst_addr[0] when dst_valid[0] & dst_addr[0]!=0.
  - dst_ok1: cnt[dst_addr[1]] + (1 if slot0 targets the same nonzero register) < MAX.
- While rst or flush is high: issue_grant = 0.
- Counter update at posedge, per register r != 0:
  - inc = number of granted slots with dst_valid & dst_addr==r (0..2).
  - dec = number of wb ports with wb_ena & wb_addr==r (0..2).
  - cnt_next = cnt + inc - dec.
  - If cnt + inc < dec: clamp cnt_next to 0 and set underflow_err.
  - Writeback to register 0 is ignored and never sets the error.
- Simultaneous inc and dec on the same register in one cycle net out. Example: cnt=1, 1 grant, 1 wb -> cnt stays 1.
- flush: all cnt go to 0 at the next edge; same-cycle wb and grants are ignored. underflow_err and stall_cnt are unaffected.
- rst: all cnt=0, underflow_err=0, stall_cnt=0.
  - Reset mid-operation discards all pending state; the first post-reset cycle grants on sources alone.
- stall_cnt: increments when issue_req[0] & !issue_grant[0] & !flush & !rst. Wraps at 2^32.
- Latency: grant is combinational in the request cycle; a counter change is visible to src_ready the next cycle.

Test Plan:
- Reset, then both slots request with srcs r1,r2,r3,r4 and no dsts -> issue_grant=2'b11; all cnt=0; stall_cnt=0.
- Grant slot0 with dst r5; next cycle slot0 reads r5 -> grant[0]=0 and stall_cnt increments each cycle. wb_ena[0]=1, wb_addr=5 -> grant[0]=1 the following cycle, not the same cycle.
- Intra-pair RAW: slot0 dst r7, slot1 src r7 -> grant=2'b01. Repeat with slot0 dst r0 -> grant=2'b11.
- Saturation: with cnt[r9]=2, both slots request dst r9 -> grant=2'b01 and cnt[r9]=3. A further request with dst r9 -> grant=0 until a wb to r9.
- Simultaneous events: cnt[r10]=2; in one cycle wb on both ports to r10 plus a slot0 grant with dst r10 -> cnt[r10]=1. A lone wb to r11 with cnt=0 -> underflow_err=1 and stays set until rst.
- Flush with cnt[r3]=3 and a wb to r3 in the same cycle -> grant=0 that cycle; next cycle cnt[r3]=0, src r3 is ready, underflow_err is unchanged.
